// File: rtl/hack_alu.sv
// hack_alu: registered Hack-style ALU with zero and negative flags, one-cycle latency.
module hack_alu #(
  parameter int WIDTH = 17
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] x,
  input  logic [WIDTH-1:0] y,
  input  logic             zx,
  input  logic             nx,
  input  logic             zy,
  input  logic             ny,
  input  logic             f,
  input  logic             no,
  output logic [WIDTH-1:0] result,
  output logic             zr,
  output logic             ng
);
  logic [WIDTH-1:0] x1, x2, y1, y2, o1, result_d, result_q;
  logic             zr_d, ng_d, zr_q, ng_q;
  always_comb begin
    x1       = zx ? '0 : x;
    x2       = nx ? ~x1 : x1;
    y1       = zy ? '0 : y;
    y2       = ny ? ~y1 : y1;
    o1       = f ? x2 + y2 : x2 & y2;
    result_d = no ? ~o1 : o1;
    zr_d     = result_d == '0;
    ng_d     = result_d[WIDTH-1];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      zr_q     <= 1'b1;
      ng_q     <= 1'b0;
    end else begin
      result_q <= result_d;
      zr_q     <= zr_d;
      ng_q     <= ng_d;
    end
  end
  assign result = result_q;
  assign zr     = zr_q;
  assign ng     = ng_q;
endmodule

// File: tb/tb_hack_alu.sv
// tb_hack_alu: directed vector table, control sweep, reset and random checks for hack_alu.
module tb_hack_alu;
  localparam int W = 17;
  localparam longint M = longint'(1) << W;
  typedef struct {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [5:0]   code;
    logic [W-1:0] res;
    logic         z;
    logic         n;
  } vec_t;
  logic         clk = 0;
  logic         rst = 1;
  logic [W-1:0] x = '0, y = '0;
  logic         zx = 0, nx = 0, zy = 0, ny = 0, f = 0, no = 0;
  logic [W-1:0] result;
  logic         zr, ng;
  int           n_chk = 0, n_fail = 0;
  vec_t         vecs[13];
  hack_alu #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .x(x), .y(y), .zx(zx), .nx(nx), .zy(zy), .ny(ny),
    .f(f), .no(no), .result(result), .zr(zr), .ng(ng)
  );
  always #5 clk = ~clk;
  // Reference computed with whole-number arithmetic: ~v is (2^W-1)-v, add wraps modulo 2^W.
  function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                         input logic [5:0] c);
    longint xv, yv, o;
    xv = c[5] ? 0 : longint'(a);
    if (c[4]) xv = M - 1 - xv;
    yv = c[3] ? 0 : longint'(b);
    if (c[2]) yv = M - 1 - yv;
    o = c[1] ? (xv + yv) % M : (xv & yv);
    if (c[0]) o = M - 1 - o;
    return {W'(o), o == 0, o >= M / 2};
  endfunction
  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask
  task automatic check_out(input string name, input logic [W-1:0] r, input logic z,
                           input logic n);
    chk({name, ".result"}, 32'(result), 32'(r));
    chk({name, ".zr"}, 32'(zr), 32'(z));
    chk({name, ".ng"}, 32'(ng), 32'(n));
  endtask
  task automatic drive(input logic [W-1:0] a, input logic [W-1:0] b, input logic [5:0] c);
    @(negedge clk);
    x = a;
    y = b;
    {zx, nx, zy, ny, f, no} = c;
  endtask
  task automatic apply_model(input string name, input logic [W-1:0] a, input logic [W-1:0] b,
                             input logic [5:0] c);
    logic [W+1:0] e;
    e = model(a, b, c);
    drive(a, b, c);
    @(posedge clk);
    #1;
    check_out(name, e[W+1:2], e[1], e[0]);
  endtask
  initial begin
    vecs[0]  = '{17'd2, 17'd2, 6'b000010, 17'd4, 1'b0, 1'b0};
    vecs[1]  = '{17'd2, 17'd2, 6'b000000, 17'd2, 1'b0, 1'b0};
    vecs[2]  = '{17'd2, 17'd2, 6'b101010, 17'd0, 1'b1, 1'b0};
    vecs[3]  = '{17'd2, 17'd2, 6'b111111, 17'd1, 1'b0, 1'b0};
    vecs[4]  = '{17'd2, 17'd2, 6'b111010, 17'h1FFFF, 1'b0, 1'b1};
    vecs[5]  = '{17'd2, 17'd2, 6'b010011, 17'd0, 1'b1, 1'b0};
    vecs[6]  = '{17'h1FFFF, 17'd1, 6'b000010, 17'd0, 1'b1, 1'b0};
    vecs[7]  = '{17'd3, 17'd5, 6'b010011, 17'h1FFFE, 1'b0, 1'b1};
    vecs[8]  = '{17'd3, 17'd5, 6'b000111, 17'd2, 1'b0, 1'b0};
    vecs[9]  = '{17'h0F0F0, 17'h00FFF, 6'b000000, 17'h000F0, 1'b0, 1'b0};
    vecs[10] = '{17'h0F0F0, 17'h00FFF, 6'b010101, 17'h0FFFF, 1'b0, 1'b0};
    vecs[11] = '{17'd5, 17'd9, 6'b001100, 17'd5, 1'b0, 1'b0};
    vecs[12] = '{17'd5, 17'd9, 6'b110000, 17'd9, 1'b0, 1'b0};
    for (int i = 0; i < 2; i++) begin
      drive(W'($urandom), W'($urandom), 6'($urandom));
      @(posedge clk);
      #1;
      check_out("reset", '0, 1'b1, 1'b0);
    end
    rst = 0;
    for (int i = 0; i < 13; i++) begin
      drive(vecs[i].a, vecs[i].b, vecs[i].code);
      @(posedge clk);
      #1;
      check_out($sformatf("vec%0d", i), vecs[i].res, vecs[i].z, vecs[i].n);
    end
    for (int c = 0; c < 64; c++) apply_model($sformatf("sweep%0d", c), 17'd2, 17'd2, 6'(c));
    apply_model("pre_rst", 17'd7, 17'd3, 6'b000010);
    drive(17'd7, 17'd3, 6'b010011);
    rst = 1;
    @(posedge clk);
    #1;
    check_out("mid_rst", '0, 1'b1, 1'b0);
    rst = 0;
    apply_model("post_rst", 17'd10, 17'd4, 6'b000111);
    apply_model("post_rst2", 17'h1FFFF, 17'h12345, 6'b000000);
    for (int i = 0; i < 300; i++)
      apply_model($sformatf("rand%0d", i), W'($urandom), W'($urandom), 6'($urandom));
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
